// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory responder (slave).
// A request is issued on req/gnt, load data returns on rvalid.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one bus access per op, byte-lane steering,
// load extension, alignment checks and a bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  load_store_unit_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       a_lo;
  logic [2:0]       f3;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;

  logic             op;
  logic             misalign_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_ext;

  assign op     = MemWriteM | MemReadM;
  assign StallM = op && (state != DONE);

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  // Alignment / legality of the incoming access
  always_comb begin
    misalign_c = 1'b1;
    case (funct3M)
      3'b000, 3'b100: misalign_c = 1'b0;
      3'b001, 3'b101: misalign_c = ALUResultM[0];
      3'b010:         misalign_c = (ALUResultM[1:0] != 2'b00);
      default:        misalign_c = 1'b1;
    endcase
  end

  // Store lane steering: enables select the lanes, data is replicated to every lane
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ALUResultM[1:0];
        wdata_c = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
      end
    endcase
  end

  // Load lane select and sign/zero extension from the latched address/funct3
  always_comb begin
    lane_b = 8'h00;
    case (a_lo)
      2'd0:    lane_b = bus.mem_rdata[7:0];
      2'd1:    lane_b = bus.mem_rdata[15:8];
      2'd2:    lane_b = bus.mem_rdata[23:16];
      default: lane_b = bus.mem_rdata[31:24];
    endcase
    lane_h   = a_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    load_ext = bus.mem_rdata;
    case (f3[1:0])
      2'b00:   load_ext = {{24{~f3[2] & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~f3[2] & lane_h[15]}}, lane_h};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_lo      <= '0;
      f3        <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      ReadDataM <= '0;
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
    end else begin
      MisalignM <= 1'b0;
      BusErrM   <= 1'b0;
      case (state)
        IDLE: begin
          if (op) begin
            a_lo <= ALUResultM[1:0];
            f3   <= funct3M;
            if (misalign_c) begin
              state     <= DONE;
              MisalignM <= 1'b1;
            end else begin
              state   <= REQ;
              cnt     <= '0;
              req_q   <= 1'b1;
              we_q    <= MemWriteM;
              addr_q  <= {ALUResultM[31:2], 2'b00};
              be_q    <= MemWriteM ? be_c : 4'b0000;
              wdata_q <= wdata_c;
            end
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            req_q <= 1'b0;
            cnt   <= cnt + CNT_W'(1);
            if (we_q) begin
              state <= DONE;
            end else if (bus.mem_rvalid) begin
              ReadDataM <= load_ext;
              state     <= DONE;
            end else begin
              state <= RESP;
            end
          end else if (cnt == CNT_LAST) begin
            req_q     <= 1'b0;
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.mem_rvalid) begin
            ReadDataM <= load_ext;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one default instance and one with a short timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        we_i, rd_i;
  logic [2:0]  f3_i;
  logic [31:0] addr_i, wd_i, rdata_i;
  logic        gnt_i, rv_i;

  logic [31:0] rd1, rd2;
  logic        st1, st2, mis1, mis2, be1e, be2e;

  load_store_unit_if b1();
  load_store_unit_if b2();

  assign b1.mem_gnt    = ~sel & gnt_i;
  assign b1.mem_rvalid = ~sel & rv_i;
  assign b1.mem_rdata  = rdata_i;
  assign b2.mem_gnt    = sel & gnt_i;
  assign b2.mem_rvalid = sel & rv_i;
  assign b2.mem_rdata  = rdata_i;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ALUResultM(addr_i), .WriteDataM(wd_i),
    .MemWriteM(we_i & ~sel), .MemReadM(rd_i & ~sel), .funct3M(f3_i),
    .ReadDataM(rd1), .StallM(st1), .MisalignM(mis1), .BusErrM(be1e), .bus(b1)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .ALUResultM(addr_i), .WriteDataM(wd_i),
    .MemWriteM(we_i & sel), .MemReadM(rd_i & sel), .funct3M(f3_i),
    .ReadDataM(rd2), .StallM(st2), .MisalignM(mis2), .BusErrM(be2e), .bus(b2)
  );

  wire        stall_o = sel ? st2 : st1;
  wire        mis_o   = sel ? mis2 : mis1;
  wire        berr_o  = sel ? be2e : be1e;
  wire [31:0] rd_o    = sel ? rd2 : rd1;
  wire        req_o   = sel ? b2.mem_req : b1.mem_req;
  wire        we_o    = sel ? b2.mem_we : b1.mem_we;
  wire [31:0] addr_o  = sel ? b2.mem_addr : b1.mem_addr;
  wire [3:0]  be_o    = sel ? b2.mem_be : b1.mem_be;
  wire [31:0] wdo_o   = sel ? b2.mem_wdata : b1.mem_wdata;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          n_stall, n_req, n_resp;
  logic        granted, saw_req, stable;
  logic [31:0] f_addr, f_wd, d_rd;
  logic [3:0]  f_be;
  logic        f_we, d_mis, d_berr, d_req;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access with a scripted responder: gnt after gw REQ cycles,
  // rvalid rg cycles after gnt (0 = same cycle). Ends back in IDLE.
  task automatic access(input logic we, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int gw, input int rg);
    we_i = we; rd_i = rd; f3_i = f3; addr_i = a; wd_i = d; rdata_i = rdata;
    gnt_i = 1'b0; rv_i = 1'b0;
    n_stall = 0; n_req = 0; n_resp = 0;
    granted = 1'b0; saw_req = 1'b0; stable = 1'b1;
    f_addr = '0; f_wd = '0; f_be = '0; f_we = 1'b0;
    #1;
    for (int c = 0; c < 50 && stall_o; c++) begin
      n_stall++;
      gnt_i = 1'b0; rv_i = 1'b0;
      if (req_o) begin
        if (!saw_req) begin
          f_addr = addr_o; f_be = be_o; f_wd = wdo_o; f_we = we_o; saw_req = 1'b1;
        end else if (addr_o !== f_addr || be_o !== f_be || wdo_o !== f_wd) begin
          stable = 1'b0;
        end
        n_req++;
        if (n_req > gw) begin
          gnt_i = 1'b1; granted = 1'b1; rv_i = (rg == 0);
        end
      end else if (granted) begin
        n_resp++;
        rv_i = (n_resp == rg);
      end
      tick();
    end
    if (stall_o) chk("access_bound", 32'(stall_o), 32'd0);
    d_mis = mis_o; d_berr = berr_o; d_rd = rd_o; d_req = req_o;
    gnt_i = 1'b0; rv_i = 1'b0; we_i = 1'b0; rd_i = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; we_i = 1'b0; rd_i = 1'b0; f3_i = 3'b000;
    addr_i = '0; wd_i = '0; rdata_i = '0; gnt_i = 1'b0; rv_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rdata", rd1, 32'h0);
    chk("rst_req", 32'(b1.mem_req), 32'h0);
    chk("rst_addr", b1.mem_addr, 32'h0);
    chk("rst_be", 32'(b1.mem_be), 32'h0);
    chk("rst_wdata", b1.mem_wdata, 32'h0);
    chk("rst_flags", {29'd0, b1.mem_we, mis1, be1e}, 32'h0);
    chk("idle_nostall", 32'(st1), 32'h0);

    // SB 0x103
    access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
    chk("sb_addr", f_addr, 32'h0000_0100);
    chk("sb_be", 32'(f_be), 32'h8);
    chk("sb_wdata", f_wd, 32'hA5A5_A5A5);
    chk("sb_we", 32'(f_we), 32'h1);
    chk("sb_stall", 32'(n_stall), 32'd2);
    chk("sb_req_done", 32'(d_req), 32'h0);

    // LB 0x102, rvalid one cycle after gnt
    access(1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 1);
    chk("lb_rdata", d_rd, 32'hFFFF_FF80);
    chk("lb_be", 32'(f_be), 32'h0);
    chk("lb_stall", 32'(n_stall), 32'd3);
    chk("lb_addr", f_addr, 32'h0000_0100);

    // LBU same, gnt+rvalid together
    access(1'b0, 1'b1, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 0, 0);
    chk("lbu_rdata", d_rd, 32'h0000_0080);
    chk("lbu_stall", 32'(n_stall), 32'd2);

    access(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 0, 1);
    chk("lhu_rdata", d_rd, 32'h0000_8001);

    access(1'b0, 1'b1, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8001, 0, 1);
    chk("lh_rdata", d_rd, 32'hFFFF_8001);

    // Misaligned LW and illegal funct3: no bus access, data held
    access(1'b0, 1'b1, 3'b010, 32'h0000_0106, 32'h0, 32'h1111_1111, 0, 0);
    chk("lw_mis_pulse", 32'(d_mis), 32'h1);
    chk("lw_mis_noreq", 32'(saw_req), 32'h0);
    chk("lw_mis_stall", 32'(n_stall), 32'd1);
    chk("lw_mis_rdata", d_rd, 32'hFFFF_8001);
    chk("mis_pulse_end", 32'(mis1), 32'h0);
    access(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 32'h1111_1111, 0, 0);
    chk("f3_011_pulse", 32'(d_mis), 32'h1);
    chk("f3_011_noreq", 32'(saw_req), 32'h0);

    // LW with gnt on 4th REQ cycle, rvalid 2 cycles later
    access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3, 2);
    chk("lwd_rdata", d_rd, 32'hDEAD_BEEF);
    chk("lwd_reqcyc", 32'(n_req), 32'd4);
    chk("lwd_stable", 32'(stable), 32'h1);
    chk("lwd_addr", f_addr, 32'h0000_0104);
    chk("lwd_stall", 32'(n_stall), 32'd7);
    chk("lwd_noberr", 32'(d_berr), 32'h0);

    access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 1, 0);
    chk("sh_be", 32'(f_be), 32'hC);
    chk("sh_wdata", f_wd, 32'hABCD_ABCD);
    chk("sh_stall", 32'(n_stall), 32'd3);
    chk("sh_rdata_held", d_rd, 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 0, 0);
    chk("sw_be", 32'(f_be), 32'hF);
    chk("sw_wdata", f_wd, 32'hCAFE_F00D);

    // Both write and read set: store wins
    access(1'b1, 1'b1, 3'b010, 32'h0000_0108, 32'h1122_3344, 32'h5555_5555, 0, 0);
    chk("both_we", 32'(f_we), 32'h1);
    chk("both_be", 32'(f_be), 32'hF);
    chk("both_rdata", d_rd, 32'hDEAD_BEEF);

    // Reset while waiting in RESP
    rd_i = 1'b1; f3_i = 3'b010; addr_i = 32'h0000_010C; rdata_i = 32'h0102_0304;
    tick();
    chk("rr_req", 32'(b1.mem_req), 32'h1);
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    chk("rr_resp_stall", {30'd0, b1.mem_req, st1}, 32'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("rr_rdata", rd1, 32'h0);
    chk("rr_req0", 32'(b1.mem_req), 32'h0);
    chk("rr_bus0", b1.mem_addr | b1.mem_wdata | 32'(b1.mem_be), 32'h0);
    rst = 1'b0; rd_i = 1'b0; rv_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
    tick();
    rv_i = 1'b0;
    tick();
    chk("rr_late_rvalid", rd1, 32'h0);
    chk("rr_idle", 32'(st1), 32'h0);

    // Short-timeout instance
    sel = 1'b1;
    access(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 32'h55AA_55AA, 0, 0);
    chk("to_load_ok", d_rd, 32'h55AA_55AA);
    access(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678, 100, 0);
    chk("to_berr", 32'(d_berr), 32'h1);
    chk("to_reqcyc", 32'(n_req), 32'd4);
    chk("to_stall", 32'(n_stall), 32'd5);
    chk("to_rdata", d_rd, 32'h0);
    chk("to_req_drop", 32'(d_req), 32'h0);
    chk("to_mis", 32'(d_mis), 32'h0);
    chk("to_berr_end", 32'(be2e), 32'h0);
    chk("to_idle_req", 32'(b2.mem_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the pipelined RISC-V core's data-memory bus. Takes the load/store request from the MEM pipeline registers, issues one request on a req/gnt/rvalid bus with byte enables, and returns sign/zero-extended load data. Stalls the pipeline until the access completes, faults, or times out. Sits between the MEM stage and the data memory responder.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in REQ+RESP before bus error (1..255, 8-bit counter)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, low-order bits significant
- MemWriteM  in  1  store request; wins over MemReadM if both set
- MemReadM  in  1  load request
- funct3M  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- ReadDataM  out  32  extended load data, registered
- StallM  out  1  hold MEM stage and earlier
- MisalignM  out  1  one-cycle pulse in DONE: misaligned or illegal funct3
- BusErrM  out  1  one-cycle pulse in DONE: timeout
- mem_req  out  1  request valid, registered
- mem_we  out  1  1 store, 0 load
- mem_addr  out  32  word address, bits [1:0] forced 0
- mem_be  out  4  byte enables (all 0 for loads)
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid this cycle
- mem_rdata  in  32  load word

## Operation
- States IDLE, REQ, RESP, DONE. op = MemWriteM | MemReadM.
- IDLE: if op, latch addr/funct3/we/data. Illegal funct3, or H/HU with addr[0]=1, or W with addr[1:0]≠0 -> DONE, MisalignM, no bus access. Else -> REQ, clear counter.
- REQ: mem_req=1, outputs stable until mem_gnt. gnt & store -> DONE. gnt & load & rvalid same cycle -> capture, DONE. gnt & load -> RESP.
- RESP: mem_req=0; mem_rvalid -> capture, DONE. mem_rvalid outside REQ/RESP ignored.
- Timeout: counter increments each REQ/RESP cycle; if count reaches TIMEOUT_CYCLES-1 with no completing event -> DONE, BusErrM, ReadDataM=0, mem_req dropped next cycle.
- DONE: StallM=0, fault pulses valid; unconditionally -> IDLE.
- Store lanes: SB be=0001<<a[1:0], wdata={4{d[7:0]}}; SH be=0011<<(2*a[1]), wdata={2{d[15:0]}}; SW be=1111.
- Load: byte = rdata[8*a[1:0]+:8], half = rdata[16*a[1]+:16]; B/H sign-extend, BU/HU zero-extend.
- StallM = op & (state≠DONE), combinational. Pipeline keeps MEM inputs stable while StallM.

## Timing
- Reset: state IDLE, counter 0; ReadDataM, mem_req, mem_we, mem_addr, mem_be, mem_wdata, MisalignM, BusErrM all 0.
- Reset mid-access: request abandoned, mem_req low on the cycle after rst; late gnt/rvalid ignored.
- Store, gnt on first REQ cycle: 3 cycles (IDLE, REQ, DONE), 2 stall cycles.
- Load, gnt then rvalid next cycle: 4 cycles, 3 stall cycles; gnt+rvalid same cycle: 3 cycles.
- Misaligned: 2 cycles (IDLE, DONE), no mem_req.
- ReadDataM updates only on capture or timeout; held otherwise (stores, faults leave it unchanged, except timeout clears it).
- No op in IDLE: StallM=0, remain IDLE. Back-to-back ops: DONE -> IDLE sees next op next cycle.

## Test plan
- SB addr 0x103, data 0x000000A5, gnt first REQ cycle -> mem_addr 0x100, mem_be 1000, mem_wdata 0xA5A5A5A5, StallM high 2 cycles.
- LB addr 0x102, rdata 0x00800000 -> ReadDataM 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, rdata 0x80010000 -> 0x00008001.
- LW addr 0x106 -> MisalignM pulse, mem_req never asserted, ReadDataM unchanged; funct3 011 same.
- LW, gnt delayed 3 cycles, rvalid 2 cycles later -> mem_req held with stable addr until gnt, ReadDataM = rdata, total stall matches cycle count.
- TIMEOUT_CYCLES=4, no gnt -> BusErrM after 4 REQ cycles, ReadDataM 0, returns IDLE.
- rst asserted in RESP -> next cycle all outputs 0, later rvalid ignored; both MemWriteM and MemReadM set -> store performed.
